c64_mem_map: RTL and testbench

- Memory/bus stage directly downstream of the CPU core.
- Consumes the core's address bus, write data and write enable, and returns the read-data byte the core samples.
- Implements the 6510 on-chip I/O port: data-direction register at $0000 and data register at $0001.
- Decodes the C64 banking (LORAM/HIRAM/CHAREN) to steer each access to RAM, BASIC ROM, KERNAL ROM, CHAR ROM or the I/O window.

---
 rtl/c64_mem_map_if.sv | 14 +
 rtl/c64_mem_map.sv | 122 ++++++++++++
 tb/tb_c64_mem_map.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/c64_mem_map_if.sv
// CPU-side bus between the 6510 core and the C64 memory map.
// Handshake: there is no valid/ready pair. The core drives ab/dout/we after a
// rising edge, the memory map returns di on the falling edge, and the core
// samples di on the next rising edge. Every access finishes in one cycle.
// The core's write-data bus is named dout because "do" is a reserved word.
interface c64_mem_map_if;
  logic [15:0] ab;
  logic [7:0]  dout;
  logic        we;
  logic [7:0]  di;

  modport master (output ab, output dout, output we, input di);
  modport slave  (input ab, input dout, input we, output di);
endinterface

// File: rtl/c64_mem_map.sv
// C64 memory map: the 6510 on-chip I/O port ($0000 DDR, $0001 data), the
// LORAM/HIRAM/CHAREN bank decode, and a read mux registered on the falling edge.
module c64_mem_map #(
  parameter int          RAM_AW      = 16,
  parameter logic [7:0]  PORT_PULLUP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  c64_mem_map_if.slave      bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [12:0]       basic_addr,
  input  logic [7:0]        basic_rdata,
  output logic [12:0]       kernal_addr,
  input  logic [7:0]        kernal_rdata,
  output logic [11:0]       char_addr,
  input  logic [7:0]        char_rdata,
  output logic              io_sel,
  output logic              io_we,
  input  logic [7:0]        io_rdata,
  input  logic [7:0]        port_in,
  output logic [7:0]        port_out,
  output logic [7:0]        port_dir
);

  typedef enum logic [2:0] {
    REG_RAM,
    REG_BASIC,
    REG_KERNAL,
    REG_CHAR,
    REG_IO,
    REG_DDR,
    REG_PDATA
  } region_t;

  logic [7:0] ddr;
  logic [7:0] pdata;
  logic [7:0] di_q;
  logic [2:0] bank;
  logic       loram;
  logic       hiram;
  logic       charen;
  region_t    region;
  logic [7:0] rd_mux;

  // Only the three banking bits of the effective port value matter for decode.
  assign bank   = (ddr[2:0] & pdata[2:0]) | (~ddr[2:0] & PORT_PULLUP[2:0]);
  assign loram  = bank[0];
  assign hiram  = bank[1];
  assign charen = bank[2];

  assign port_out = ddr & pdata;
  assign port_dir = ddr;

  assign ram_addr    = bus.ab[RAM_AW-1:0];
  assign ram_wdata   = bus.dout;
  assign basic_addr  = bus.ab[12:0];
  assign kernal_addr = bus.ab[12:0];
  assign char_addr   = bus.ab[11:0];

  // Region decode from the current address and the banking lines.
  always_comb begin
    region = REG_RAM;
    if (bus.ab == 16'h0000) begin
      region = REG_DDR;
    end else if (bus.ab == 16'h0001) begin
      region = REG_PDATA;
    end else begin
      case (bus.ab[15:12])
        4'hA, 4'hB: region = (loram && hiram) ? REG_BASIC : REG_RAM;
        4'hE, 4'hF: region = hiram ? REG_KERNAL : REG_RAM;
        4'hD: begin
          if (!loram && !hiram) region = REG_RAM;
          else if (charen)      region = REG_IO;
          else                  region = REG_CHAR;
        end
        default: region = REG_RAM;
      endcase
    end
  end

  // Write strobes; a cycle with reset asserted never writes anything.
  assign io_sel = (region == REG_IO);
  assign io_we  = bus.we & io_sel & ~reset;
  assign ram_we = bus.we & ~io_sel & ~reset;

  // Read data source for the current address.
  always_comb begin
    rd_mux = ram_rdata;
    case (region)
      REG_BASIC:  rd_mux = basic_rdata;
      REG_KERNAL: rd_mux = kernal_rdata;
      REG_CHAR:   rd_mux = char_rdata;
      REG_IO:     rd_mux = io_rdata;
      REG_DDR:    rd_mux = ddr;
      REG_PDATA:  rd_mux = (ddr & pdata) | (~ddr & port_in);
      default:    rd_mux = ram_rdata;
    endcase
  end

  // Port registers update on the rising edge that ends the write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr   <= 8'h00;
      pdata <= 8'h00;
    end else if (bus.we) begin
      if (bus.ab == 16'h0000) ddr <= bus.dout;
      if (bus.ab == 16'h0001) pdata <= bus.dout;
    end
  end

  // Read data is captured on the falling edge, giving a half-cycle read.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) di_q <= 8'h00;
    else       di_q <= rd_mux;
  end

  assign bus.di = di_q;

endmodule

// File: tb/tb_c64_mem_map.sv
// Directed bench for c64_mem_map with a behavioural 64 KB RAM and constant ROM/IO bytes.
module tb_c64_mem_map;

  localparam logic [7:0] BASIC_B  = 8'h94;
  localparam logic [7:0] KERNAL_B = 8'h85;
  localparam logic [7:0] CHAR_B   = 8'hC3;
  localparam logic [7:0] IO_B     = 8'h1E;

  logic        clk;
  logic        reset;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [12:0] basic_addr;
  logic [12:0] kernal_addr;
  logic [11:0] char_addr;
  logic        io_sel;
  logic        io_we;
  logic [7:0]  port_in;
  logic [7:0]  port_out;
  logic [7:0]  port_dir;
  logic [7:0]  mem [65536];

  int n_vec;
  int n_err;

  c64_mem_map_if bus ();

  c64_mem_map dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .basic_addr   (basic_addr),
    .basic_rdata  (BASIC_B),
    .kernal_addr  (kernal_addr),
    .kernal_rdata (KERNAL_B),
    .char_addr    (char_addr),
    .char_rdata   (CHAR_B),
    .io_sel       (io_sel),
    .io_we        (io_we),
    .io_rdata     (IO_B),
    .port_in      (port_in),
    .port_out     (port_out),
    .port_dir     (port_dir)
  );

  // Clock: 10 time units, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the rising edge.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  function automatic logic [7:0] ram_init(input int a);
    logic [15:0] v;
    v = a[15:0];
    return v[7:0] ^ v[15:8];
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU cycle: drive after the rising edge, return after di is captured.
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(posedge clk);
    #1;
    bus.ab   = a;
    bus.dout = d;
    bus.we   = w;
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) mem[i] = ram_init(i);
    reset    = 1'b1;
    port_in  = 8'h00;
    bus.ab   = 16'hE000;
    bus.dout = 8'h00;
    bus.we   = 1'b0;
    #1;
    check("reset_di", {8'h00, bus.di}, 16'h0000);
    check("reset_dir", {8'h00, port_dir}, 16'h0000);
    check("reset_out", {8'h00, port_out}, 16'h0000);
    #6;
    reset = 1'b0;

    // Default mapping: BASIC, KERNAL and I/O visible.
    cpu_cycle(16'hE000, 8'h00, 1'b0);
    check("kernal_rd", {8'h00, bus.di}, {8'h00, KERNAL_B});
    cpu_cycle(16'hA000, 8'h00, 1'b0);
    check("basic_rd", {8'h00, bus.di}, {8'h00, BASIC_B});
    cpu_cycle(16'hD020, 8'h00, 1'b0);
    check("io_sel_d020", {15'h0, io_sel}, 16'h0001);
    check("io_rd", {8'h00, bus.di}, {8'h00, IO_B});

    // All RAM: DDR=$07, data=$00.
    cpu_cycle(16'h0000, 8'h07, 1'b1);
    check("ddr_wr_ram_we", {15'h0, ram_we}, 16'h0001);
    cpu_cycle(16'h0001, 8'h00, 1'b1);
    cpu_cycle(16'hA000, 8'h00, 1'b0);
    check("port_out_0", {8'h00, port_out}, 16'h0000);
    check("port_dir_7", {8'h00, port_dir}, 16'h0007);
    check("ram_a000", {8'h00, bus.di}, {8'h00, ram_init(16'hA000)});
    cpu_cycle(16'hD000, 8'h00, 1'b0);
    check("ram_d000", {8'h00, bus.di}, {8'h00, ram_init(16'hD000)});
    check("io_sel_ram", {15'h0, io_sel}, 16'h0000);
    cpu_cycle(16'hE000, 8'h00, 1'b0);
    check("ram_e000", {8'h00, bus.di}, {8'h00, ram_init(16'hE000)});

    // CHAREN=0 shows CHAR ROM, then back to I/O.
    cpu_cycle(16'h0001, 8'h03, 1'b1);
    cpu_cycle(16'hD000, 8'h00, 1'b0);
    check("char_rd", {8'h00, bus.di}, {8'h00, CHAR_B});
    check("char_io_sel", {15'h0, io_sel}, 16'h0000);
    cpu_cycle(16'h0001, 8'h07, 1'b1);
    cpu_cycle(16'hD000, 8'h00, 1'b0);
    check("io_back_sel", {15'h0, io_sel}, 16'h0001);
    check("io_back_rd", {8'h00, bus.di}, {8'h00, IO_B});

    // Write under BASIC lands in RAM; clear LORAM to read it back.
    cpu_cycle(16'hA123, 8'h5A, 1'b1);
    check("shadow_ram_we", {15'h0, ram_we}, 16'h0001);
    check("shadow_addr", ram_addr, 16'hA123);
    check("shadow_io_we", {15'h0, io_we}, 16'h0000);
    cpu_cycle(16'h0001, 8'h06, 1'b1);
    cpu_cycle(16'hA123, 8'h00, 1'b0);
    check("shadow_rd", {8'h00, bus.di}, 16'h005A);
    cpu_cycle(16'hE000, 8'h00, 1'b0);
    check("kernal_hiram", {8'h00, bus.di}, {8'h00, KERNAL_B});

    // Mixed port directions.
    port_in = 8'hA0;
    cpu_cycle(16'h0000, 8'h0F, 1'b1);
    cpu_cycle(16'h0001, 8'h05, 1'b1);
    cpu_cycle(16'h0001, 8'h00, 1'b0);
    check("port_rd_0001", {8'h00, bus.di}, 16'h00A5);
    cpu_cycle(16'h0000, 8'h00, 1'b0);
    check("port_rd_0000", {8'h00, bus.di}, 16'h000F);
    check("port_out_5", {8'h00, port_out}, 16'h0005);

    // I/O write (LORAM=1, HIRAM=0, CHAREN=1) goes to I/O only.
    cpu_cycle(16'hD020, 8'h33, 1'b1);
    check("io_we", {15'h0, io_we}, 16'h0001);
    check("io_wr_ram_we", {15'h0, ram_we}, 16'h0000);

    // Reset in the middle of a port write cycle.
    cpu_cycle(16'h0001, 8'hFF, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_ram_we", {15'h0, ram_we}, 16'h0000);
    check("rst_mid_di", {8'h00, bus.di}, 16'h0000);
    @(posedge clk);
    #2;
    bus.we = 1'b0;
    check("rst_dir", {8'h00, port_dir}, 16'h0000);
    check("rst_out", {8'h00, port_out}, 16'h0000);
    reset = 1'b0;
    cpu_cycle(16'hE000, 8'h00, 1'b0);
    check("rst_kernal", {8'h00, bus.di}, {8'h00, KERNAL_B});
    check("rst_dir_after", {8'h00, port_dir}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
